// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register transaction controller:
// command byte layout, default sizing and FSM state encoding.
package spi_reg_pkg;

    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_INC_BIT  = 6;
    localparam int CMD_ADDR_MSB = 5;

    localparam int ADDR_W_DEF   = 6;
    localparam int NUM_REGS_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_REQ,
        RD_CAP,
        RD_STREAM
    } state_e;

endpackage

// File: rtl/spi_reg_ctrl.sv
// Turns the SPI bridge byte stream into register-port reads and writes,
// with optional address auto-increment and a prefetched read path.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata
);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              inc;
    logic              addr_ok;

    assign addr_ok = int'(addr) < NUM_REGS;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // cs_n high ends the transaction from any state, including in-flight reads.
    always_comb begin
        state_nxt = state;
        if (cs_n) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:      if (byte_sync) state_nxt = data_in[CMD_WR_BIT] ? WR_DATA : RD_REQ;
                WR_DATA:   state_nxt = WR_DATA;
                RD_REQ:    state_nxt = RD_CAP;
                RD_CAP:    state_nxt = RD_STREAM;
                RD_STREAM: if (byte_sync) state_nxt = RD_REQ;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        reg_re = (state == RD_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            inc       <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            data_out  <= '0;
        end else begin
            reg_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (byte_sync && !cs_n) begin
                        addr     <= ADDR_W'(data_in[CMD_ADDR_MSB:0]);
                        inc      <= data_in[CMD_INC_BIT];
                        reg_addr <= ADDR_W'(data_in[CMD_ADDR_MSB:0]);
                    end
                end
                // A data byte arriving together with cs_n rising still commits.
                WR_DATA: begin
                    if (byte_sync) begin
                        reg_we    <= addr_ok;
                        reg_wdata <= data_in;
                        reg_addr  <= addr;
                        if (inc) addr <= addr + ADDR_W'(1);
                    end
                end
                RD_CAP: begin
                    data_out <= addr_ok ? reg_rdata : '0;
                end
                RD_STREAM: begin
                    if (byte_sync && !cs_n && inc) begin
                        addr     <= addr + ADDR_W'(1);
                        reg_addr <= addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
            if (cs_n) data_out <= '0;
        end
    end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Transaction controller between the SPI byte bridge and the PWM register bank.
- Parses the byte stream from the bridge (byte_sync / data_in) into register reads and writes.
- Drives single-cycle strobes on a simple register port.
- Supplies read data back to the bridge on data_out, with optional address auto-increment for burst access.

Parameters:
ADDR_W, 6, register address width; equals the command address field width.
DATA_W, 8, data width; fixed to the SPI byte width.
NUM_REGS, 16, number of implemented registers; addresses >= NUM_REGS are illegal.

Ports:
clk  in  1  peripheral clock, same clock as the SPI bridge.
rst  in  1  synchronous, active-high reset.
cs_n  in  1  SPI chip select, already in the clk domain; high = transaction over.
byte_sync  in  1  one-cycle pulse: data_in holds a newly received byte.
data_in  in  8  received byte.
data_out  out  8  byte the bridge loads at the next byte boundary.
reg_addr  out  ADDR_W  register address.
reg_wdata  out  8  write data.
reg_we  out  1  one-cycle write strobe.
reg_re  out  1  one-cycle read strobe.
reg_rdata  in  8  read data, valid exactly 1 clk after reg_re.

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE; data_out=0x00, reg_addr=0, reg_wdata=0x00, reg_we=0, reg_re=0; internal address, write and burst flags cleared. rst has priority over everything.
- Command byte = first byte after cs_n falls:
  - bit7 = write(1) / read(0).
  - bit6 = auto-increment enable.
  - bits5:0 = start address.
- IDLE:
  - data_out=0x00.
  - On byte_sync: latch address and flags, drive reg_addr=address.
  - Write command -> WR_DATA. Read command -> RD_REQ.
- WR_DATA, on byte_sync:
  - Next cycle: reg_we=1 for exactly one cycle, reg_wdata=data_in, reg_addr=current address.
  - If address >= NUM_REGS: reg_we is suppressed (write silently dropped).
  - Then, if auto-increment is set: address+1, wrapping 63->0. Stay in WR_DATA.
- RD_REQ (entered the cycle after the command byte_sync):
  - reg_re=1 for one cycle at the current address. -> RD_CAP.
- RD_CAP:
  - data_out <= reg_rdata, or 0x00 if the address is illegal. -> RD_STREAM.
  - Total latency from command byte_sync to data_out valid: 3 clk. This is far shorter than one SPI byte.
- RD_STREAM:
  - data_out was loaded by the bridge at the end of SPI byte 1 and is shifted out during byte 2. Byte 1 is a turnaround byte; its MISO is don't-care.
  - On byte_sync (end of byte 1, 2, ...): data_in is ignored. If auto-increment: address+1 (wrap), then RD_REQ -> RD_CAP prefetch. Otherwise re-read the same address.
  - A read of N registers therefore takes 1 cmd + 1 turnaround + N data bytes.
- cs_n high in any state:
  - Next cycle: state=IDLE, data_out=0x00, no new strobes.
  - Any in-flight RD_REQ/RD_CAP is aborted: reg_re may already have fired, but its data is discarded.
- Simultaneous byte_sync and cs_n high in the same cycle:
  - WR_DATA: the write is still committed, then IDLE.
  - IDLE: the command is discarded.
  - RD_STREAM: no prefetch.
- reg_we and reg_re are never high in the same cycle. At most one strobe per received byte.
- The address counter is ADDR_W bits, so the wrap is natural modulo 2^ADDR_W.

Decomposition:
- Shared package spi_reg_pkg holds:
  - CMD_WR_BIT=7, CMD_INC_BIT=6, CMD_ADDR_MSB=5.
  - ADDR_W, NUM_REGS defaults.
  - State encoding: IDLE, WR_DATA, RD_REQ, RD_CAP, RD_STREAM.
- No sub-module. The FSM, address counter and data_out register are one block of roughly 150-250 lines.

Test Plan:
1. Write: cs_n low, bytes 0x83, 0x5A -> exactly one reg_we pulse with reg_addr=3, reg_wdata=0x5A; no reg_re.
2. Burst write wrap: bytes 0xFF, 0x11, 0x22 with NUM_REGS=64 -> writes (63,0x11) then (0,0x22).
3. Burst read: regs 4..6 = 0xA1, 0xB2, 0xC3; bytes 0x44, 0x00, 0x00, 0x00, 0x00 -> MISO reads 0x00, 0x00, 0xA1, 0xB2, 0xC3; data_out valid 3 clk after the first byte_sync.
4. Illegal address: write 0x94 (addr 20, NUM_REGS=16) with 0x77 -> no reg_we. Read 0x14 -> returns 0x00.
5. Abort: cs_n rises one cycle after the command byte_sync of read 0x02 -> IDLE within 1 clk, data_out=0x00. The next transaction, write 0x81, 0x33, writes reg1=0x33 correctly.
6. Reset mid-write: rst=1 during WR_DATA at the byte_sync cycle -> no reg_we; all outputs 0 next cycle; state IDLE.
